vxe_txnreq_decoder: RTL and testbench
=====================================

# vxe_txnreq_decoder

Receiving end of the VxEngine request transaction link. It accepts packed request vectors (transaction word plus data word) over a valid/ready handshake and buffers them in a small FIFO. It then presents the unpacked fields (txn id, direction, address, write data, byte enables) to the downstream memory-side consumer through a second valid/ready handshake. It sits at the memory-port side of the link, opposite the request coder inside each client.

## Interface
Parameters:
- DEPTH_LOG2, default 1: log2 of FIFO depth (depth = 2^DEPTH_LOG2). Legal values are 1..4.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- nrst  in  1  asynchronous active-low reset.
- i_req_vec_txn  in  44  transaction word. Bit layout: [43:38] txn id, [37] rnw, [36:0] upper 37 bits of the 40-bit address.
- i_req_vec_dat  in  72  data word. Bit layout: [71:64] byte enables, [63:0] write data.
- i_req_valid  in  1  upstream request valid.
- o_req_rdy  out  1  decoder can accept a request.
- o_txnid  out  6  decoded transaction id.
- o_rnw  out  1  1 = read, 0 = write.
- o_addr  out  37  decoded address (upper 37 bits).
- o_data  out  64  write data; zero for reads.
- o_ben  out  8  byte enables, passed through for both reads and writes.
- o_valid  out  1  decoded request available.
- i_rdy  in  1  downstream consumer accepts the head request.
- o_count  out  DEPTH_LOG2+1  current FIFO occupancy.
- o_err  out  1  one-cycle pulse when a malformed write is dropped (configuration-dependent).

## Operation
- Push: occurs when i_req_valid && o_req_rdy. The entry is stored unpacked: {txnid, rnw, addr, rnw ? 64'h0 : data, ben}. Read data is zeroed at push time.
- Pop: occurs when o_valid && i_rdy. The head entry is discarded and the read pointer advances.
- o_req_rdy = (count != depth). It is derived from state only and never depends on i_req_valid or i_rdy in the same cycle.
- o_valid = (count != 0).
- The output fields always show the head entry. When o_valid = 0 they hold the last head contents, and consumers must ignore them.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo depth. count is DEPTH_LOG2+1 bits wide.
- Simultaneous push and pop:
  - count is unchanged.
  - Both pointers advance.
  - This is legal at any nonzero occupancy below full.
  - When full, push is blocked by o_req_rdy = 0, so a pop when full only decrements.
- Push when empty: there is no combinational bypass. The entry becomes visible on the next cycle.
- Upstream contract: while i_req_valid is high and o_req_rdy is low, the inputs must stay stable. The decoder does not check this.
- Downstream ordering: entries are returned in arrival order (strict FIFO, no reordering by txn id).

## Timing
- Reset (nrst low, asynchronous), with values held until the first clk edge after release:
  - count = 0, pointers = 0.
  - o_valid = 0, o_req_rdy = 1, o_count = 0, o_err = 0.
  - o_txnid, o_rnw, o_addr, o_data, o_ben = 0, because storage is reset.
- Latency: a push in cycle N gives o_valid = 1 with the fields in cycle N+1.
- Throughput: one request per cycle in steady state with i_rdy held high. Depth 2 is sufficient for full rate.
- Reset mid-operation clears all entries. In-flight requests are lost and no o_err is raised.
- o_err is registered: it asserts in the cycle after the offending handshake and lasts exactly one cycle.

## Configuration
- VXE_TXNREQ_DEC_BENCHK_EN defined:
  - A write request (rnw = 0) with byte enables == 8'h00 is still handshaken (o_req_rdy behaves normally) but is not stored.
  - count and the pointers are unaffected by it.
  - o_err pulses high the cycle after.
  - Reads with ben == 0 are stored normally.
- Macro not defined:
  - All requests are stored unconditionally.
  - o_err is driven constant 0.

## Test plan
- Reset then idle:
  - Expect o_req_rdy = 1, o_valid = 0, o_count = 0, all fields 0.
- Single write: push txn = {6'h2A, 1'b0, 37'h0_1234_5678}, dat = {8'hF0, 64'hDEAD_BEEF_CAFE_F00D} in cycle N.
  - In cycle N+1: o_valid = 1, o_txnid = 6'h2A, o_rnw = 0, o_addr = 37'h0_1234_5678, o_data = 64'hDEAD_BEEF_CAFE_F00D, o_ben = 8'hF0.
- Read data zeroing: push rnw = 1 with data 64'hFFFF_FFFF_FFFF_FFFF, ben = 8'hFF.
  - Expect o_data = 0, o_ben = 8'hFF.
- Fill and backpressure (DEPTH_LOG2 = 1): hold i_rdy = 0 and push ids 1, 2, 3.
  - After two pushes: o_count = 2, o_req_rdy = 0, and id 3 is held.
  - Raise i_rdy: output order is 1, 2, 3, with id 3 accepted the cycle after the first pop.
- Streaming: push 8 requests back-to-back with i_rdy = 1 and simultaneous push/pop.
  - Expect 8 consecutive pops in order, o_count never exceeding 1, and pointer wrap checked.
- With VXE_TXNREQ_DEC_BENCHK_EN: push a write with ben = 0, then a valid write.
  - Expect o_err high for exactly one cycle and only the valid write to appear.
  - Without the macro, both writes appear and o_err stays 0.

Source files
------------

// File: rtl/vxe_txnreq_decoder.sv
// vxe_txnreq_decoder: memory-side receiver of the VxEngine request link.
// Accepts packed {txn, dat} request vectors, unpacks them into a small FIFO
// (depth 2**DEPTH_LOG2) and presents the head entry's fields downstream.
// Optional feature macro: VXE_TXNREQ_DEC_BENCHK_EN. When it is defined, a
// write with all byte enables clear is accepted but dropped, and o_err
// pulses for one cycle.
module vxe_txnreq_decoder #(
  parameter int DEPTH_LOG2 = 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [43:0]           i_req_vec_txn,
  input  logic [71:0]           i_req_vec_dat,
  input  logic                  i_req_valid,
  output logic                  o_req_rdy,
  output logic [5:0]            o_txnid,
  output logic                  o_rnw,
  output logic [36:0]           o_addr,
  output logic [63:0]           o_data,
  output logic [7:0]            o_ben,
  output logic                  o_valid,
  input  logic                  i_rdy,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_err
);

  localparam int                DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(DEPTH);

  typedef struct packed {
    logic [5:0]  txnid;
    logic        rnw;
    logic [36:0] addr;
    logic [63:0] data;
    logic [7:0]  ben;
  } entry_t;

  entry_t                mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;

  logic   hs;      // upstream handshake
  logic   drop;    // handshaken but not stored
  logic   push;
  logic   pop;
  entry_t wr_ent;
  entry_t head;

  assign o_req_rdy = (count_q != FULL);
  assign o_valid   = (count_q != '0);
  assign hs        = i_req_valid && o_req_rdy;
  assign pop       = o_valid && i_rdy;

`ifdef VXE_TXNREQ_DEC_BENCHK_EN
  logic err_q;

  assign drop = hs && !i_req_vec_txn[37] && (i_req_vec_dat[71:64] == 8'h00);

  // Registered one-cycle error pulse for a dropped empty-enable write.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) err_q <= 1'b0;
    else       err_q <= drop;
  end

  assign o_err = err_q;
`else
  assign drop  = 1'b0;
  assign o_err = 1'b0;
`endif

  assign push = hs && !drop;

  // Unpack the request; read data is zeroed before it is stored.
  always_comb begin
    wr_ent       = '0;
    wr_ent.txnid = i_req_vec_txn[43:38];
    wr_ent.rnw   = i_req_vec_txn[37];
    wr_ent.addr  = i_req_vec_txn[36:0];
    wr_ent.data  = i_req_vec_txn[37] ? 64'h0 : i_req_vec_dat[63:0];
    wr_ent.ben   = i_req_vec_dat[71:64];
  end

  // Next-state for occupancy and pointers; pointers wrap modulo depth.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; cleared on reset so the output fields read zero.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wptr_q] <= wr_ent;
    end
  end

  assign head    = mem_q[rptr_q];
  assign o_txnid = head.txnid;
  assign o_rnw   = head.rnw;
  assign o_addr  = head.addr;
  assign o_data  = head.data;
  assign o_ben   = head.ben;
  assign o_count = count_q;

endmodule

// File: tb/tb_vxe_txnreq_decoder.sv
// Bench for vxe_txnreq_decoder: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_vxe_txnreq_decoder;

  localparam int DL2   = 1;
  localparam int DEPTH = 1 << DL2;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [43:0]   i_req_vec_txn = '0;
  logic [71:0]   i_req_vec_dat = '0;
  logic          i_req_valid = 1'b0;
  logic          o_req_rdy;
  logic [5:0]    o_txnid;
  logic          o_rnw;
  logic [36:0]   o_addr;
  logic [63:0]   o_data;
  logic [7:0]    o_ben;
  logic          o_valid;
  logic          i_rdy = 1'b0;
  logic [DL2:0]  o_count;
  logic          o_err;

  vxe_txnreq_decoder #(.DEPTH_LOG2(DL2)) dut (
    .clk(clk), .nrst(nrst),
    .i_req_vec_txn(i_req_vec_txn), .i_req_vec_dat(i_req_vec_dat),
    .i_req_valid(i_req_valid), .o_req_rdy(o_req_rdy),
    .o_txnid(o_txnid), .o_rnw(o_rnw), .o_addr(o_addr), .o_data(o_data),
    .o_ben(o_ben), .o_valid(o_valid), .i_rdy(i_rdy),
    .o_count(o_count), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Entry = {txnid, rnw, addr, data, ben}, 116 bits.
  logic [115:0] mq[$];
  logic         err_exp = 1'b0;

  function automatic logic [115:0] unpack(input logic [43:0] t, input logic [71:0] d);
    return {t[43:38], t[37], t[36:0], (t[37] ? 64'h0 : d[63:0]), d[71:64]};
  endfunction

  function automatic bit is_drop(input logic [43:0] t, input logic [71:0] d);
`ifdef VXE_TXNREQ_DEC_BENCHK_EN
    return (t[37] == 1'b0) && (d[71:64] == 8'h00);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mq.delete();
      err_exp <= 1'b0;
    end else begin
      bit acc, dq;
      acc = i_req_valid && (mq.size() < DEPTH);
      dq  = acc && is_drop(i_req_vec_txn, i_req_vec_dat);
      if ((mq.size() > 0) && i_rdy) void'(mq.pop_front());
      if (acc && !dq) mq.push_back(unpack(i_req_vec_txn, i_req_vec_dat));
      err_exp <= dq;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("count", 128'(o_count), 128'(mq.size()));
    chk("valid", 128'(o_valid), 128'(mq.size() != 0));
    chk("req_rdy", 128'(o_req_rdy), 128'(mq.size() < DEPTH));
    chk("err", 128'(o_err), 128'(err_exp));
    if (mq.size() != 0)
      chk("head", 128'({o_txnid, o_rnw, o_addr, o_data, o_ben}), 128'(mq[0]));
  end

  // Observation helpers for directed scenarios.
  logic [5:0] popped[$];
  int         maxcnt = 0;
  int         errcyc = 0;
  always @(negedge clk) begin
    if (nrst && o_valid && i_rdy) popped.push_back(o_txnid);
    if (int'(o_count) > maxcnt) maxcnt = int'(o_count);
    if (o_err) errcyc++;
  end

  // Present a request and hold it until accepted; ncyc = edges waited.
  task automatic send(input logic [43:0] t, input logic [71:0] d, output int ncyc);
    bit ok;
    ncyc = 0;
    i_req_vec_txn = t;
    i_req_vec_dat = d;
    i_req_valid   = 1'b1;
    do begin
      @(negedge clk);
      ok = o_req_rdy;
      @(posedge clk); #1;
      ncyc++;
    end while (!ok && ncyc < 50);
    if (!ok) begin
      fails++;
      tests++;
      $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
    end
    i_req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int nc;
  bit hold;

  initial begin
    // Reset and idle
    #12;
    @(negedge clk);
    chk("rst_rdy", 128'(o_req_rdy), 128'(1));
    chk("rst_valid", 128'(o_valid), 128'(0));
    chk("rst_count", 128'(o_count), 128'(0));
    chk("rst_fields", 128'({o_txnid, o_rnw, o_addr, o_data, o_ben}), 128'(0));
    @(posedge clk); #1;
    nrst = 1'b1;
    idle(2);

    // Single write
    i_rdy = 1'b0;
    send({6'h2A, 1'b0, 37'h0_1234_5678}, {8'hF0, 64'hDEAD_BEEF_CAFE_F00D}, nc);
    @(negedge clk);
    chk("wr_valid", 128'(o_valid), 128'(1));
    chk("wr_txnid", 128'(o_txnid), 128'(6'h2A));
    chk("wr_rnw", 128'(o_rnw), 128'(0));
    chk("wr_addr", 128'(o_addr), 128'(37'h0_1234_5678));
    chk("wr_data", 128'(o_data), 128'(64'hDEAD_BEEF_CAFE_F00D));
    chk("wr_ben", 128'(o_ben), 128'(8'hF0));
    @(posedge clk); #1;
    i_rdy = 1'b1;
    idle(2);

    // Read data zeroing
    i_rdy = 1'b0;
    send({6'h05, 1'b1, 37'h1F_0000_0040}, {8'hFF, 64'hFFFF_FFFF_FFFF_FFFF}, nc);
    @(negedge clk);
    chk("rd_data", 128'(o_data), 128'(0));
    chk("rd_ben", 128'(o_ben), 128'(8'hFF));
    chk("rd_rnw", 128'(o_rnw), 128'(1));
    @(posedge clk); #1;
    i_rdy = 1'b1;
    idle(2);

    // Fill and backpressure
    i_rdy = 1'b0;
    popped.delete();
    send({6'd1, 1'b0, 37'h11}, {8'h01, 64'h1}, nc);
    send({6'd2, 1'b0, 37'h22}, {8'h03, 64'h2}, nc);
    i_req_vec_txn = {6'd3, 1'b0, 37'h33};
    i_req_vec_dat = {8'h07, 64'h3};
    i_req_valid   = 1'b1;
    @(negedge clk);
    chk("bp_count", 128'(o_count), 128'(2));
    chk("bp_rdy", 128'(o_req_rdy), 128'(0));
    @(posedge clk); #1;
    i_rdy = 1'b1;
    send({6'd3, 1'b0, 37'h33}, {8'h07, 64'h3}, nc);
    chk("bp_id3_delay", 128'(nc), 128'(2));
    idle(4);
    chk("bp_npop", 128'(popped.size()), 128'(3));
    if (popped.size() == 3) begin
      chk("bp_ord0", 128'(popped[0]), 128'(1));
      chk("bp_ord1", 128'(popped[1]), 128'(2));
      chk("bp_ord2", 128'(popped[2]), 128'(3));
    end

    // Streaming with simultaneous push/pop; wraps the pointers several times
    popped.delete();
    maxcnt = 0;
    for (int k = 0; k < 8; k++) begin
      send({6'(10 + k), 1'b0, 37'(k * 8)}, {8'hFF, 64'(k)}, nc);
      chk("st_b2b", 128'(nc), 128'(1));
    end
    idle(3);
    chk("st_maxcnt", 128'(maxcnt), 128'(1));
    chk("st_npop", 128'(popped.size()), 128'(8));
    for (int k = 0; k < 8 && k < popped.size(); k++)
      chk("st_order", 128'(popped[k]), 128'(10 + k));

    // Empty-enable write followed by a good write
    popped.delete();
    errcyc = 0;
    send({6'h20, 1'b0, 37'h100}, {8'h00, 64'hAAAA}, nc);
    send({6'h21, 1'b0, 37'h200}, {8'h0F, 64'hBBBB}, nc);
    idle(4);
`ifdef VXE_TXNREQ_DEC_BENCHK_EN
    chk("be_errcyc", 128'(errcyc), 128'(1));
    chk("be_npop", 128'(popped.size()), 128'(1));
    if (popped.size() >= 1) chk("be_id", 128'(popped[0]), 128'(6'h21));
`else
    chk("be_errcyc", 128'(errcyc), 128'(0));
    chk("be_npop", 128'(popped.size()), 128'(2));
    if (popped.size() >= 2) chk("be_id", 128'(popped[1]), 128'(6'h21));
`endif

    // Random traffic obeying the upstream hold contract
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      hold = i_req_valid && !o_req_rdy;
      @(posedge clk); #1;
      if (!hold) begin
        i_req_valid   = ($urandom_range(0, 3) != 0);
        i_req_vec_txn = {$urandom(), 12'($urandom())};
        i_req_vec_dat = {($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom()),
                         $urandom(), $urandom()};
      end
      i_rdy = ($urandom_range(0, 2) != 0);
      if (c == 400) begin
        // Mid-operation reset drops everything without an error pulse
        nrst = 1'b0;
        #2;
        chk("mrst_count", 128'(o_count), 128'(0));
        chk("mrst_err", 128'(o_err), 128'(0));
        chk("mrst_fields", 128'({o_txnid, o_rnw, o_addr, o_data, o_ben}), 128'(0));
        @(posedge clk); #1;
        nrst = 1'b1;
      end
    end
    i_req_valid = 1'b0;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
